// File: rtl/f_register_file.sv
// f_register_file: FP register array with sticky fflags, frm and a pending-write scoreboard
module f_register_file #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [4:0]        f_rs1,
    input  logic [4:0]        f_rs2,
    input  logic [4:0]        f_rd,
    input  logic              f_wen,
    input  logic [DATA_W-1:0] f_w_data,
    input  logic              f_NV,
    input  logic              f_DZ,
    input  logic              f_OF,
    input  logic              f_UF,
    input  logic              f_NX,
    input  logic              csr_fflags_wen,
    input  logic [4:0]        csr_fflags_in,
    input  logic              csr_frm_wen,
    input  logic [2:0]        f_frm_in,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    output logic [DATA_W-1:0] f_rs1_data,
    output logic [DATA_W-1:0] f_rs2_data,
    output logic [2:0]        f_frm_out,
    output logic [4:0]        f_flags,
    output logic              f_rs1_busy,
    output logic              f_rs2_busy
);
    localparam int AW = $clog2(NREGS);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic [4:0]        fflags;
    logic [2:0]        frm;
    logic [AW-1:0]     ra1;
    logic [AW-1:0]     ra2;
    logic [AW-1:0]     wa;
    logic [AW-1:0]     ia;
    logic              fwd1;
    logic              fwd2;

    // address bits above the index width are ignored
    assign ra1 = f_rs1[AW-1:0];
    assign ra2 = f_rs2[AW-1:0];
    assign wa  = f_rd[AW-1:0];
    assign ia  = issue_rd[AW-1:0];

    assign fwd1 = BYPASS && f_wen && (wa == ra1);
    assign fwd2 = BYPASS && f_wen && (wa == ra2);

    assign f_rs1_data = fwd1 ? f_w_data : regs[ra1];
    assign f_rs2_data = fwd2 ? f_w_data : regs[ra2];
    assign f_rs1_busy = busy[ra1] & ~fwd1;
    assign f_rs2_busy = busy[ra2] & ~fwd2;
    assign f_flags    = fflags;
    assign f_frm_out  = frm;

    // set after clear so a re-issued destination stays pending
    always_comb begin
        busy_nxt = busy;
        if (f_wen)
            busy_nxt[wa] = 1'b0;
        if (issue_valid)
            busy_nxt[ia] = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy   <= '0;
            fflags <= '0;
            frm    <= '0;
        end else begin
            if (f_wen)
                regs[wa] <= f_w_data;
            fflags <= csr_fflags_wen ? csr_fflags_in
                    : f_wen ? (fflags | {f_NV, f_DZ, f_OF, f_UF, f_NX}) : fflags;
            if (csr_frm_wen && f_frm_in <= 3'b100)
                frm <= f_frm_in;
            busy <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_f_register_file.sv
// tb_f_register_file: directed self-checking bench for f_register_file
module tb_f_register_file;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [4:0]  f_rs1, f_rs2, f_rd, csr_fflags_in, issue_rd;
    logic        f_wen, f_NV, f_DZ, f_OF, f_UF, f_NX;
    logic        csr_fflags_wen, csr_frm_wen, issue_valid;
    logic [31:0] f_w_data;
    logic [2:0]  f_frm_in;
    logic [31:0] f_rs1_data, f_rs2_data;
    logic [2:0]  f_frm_out;
    logic [4:0]  f_flags;
    logic        f_rs1_busy, f_rs2_busy;
    int          n_checks = 0;
    int          n_fail = 0;

    f_register_file #(.NREGS(32), .DATA_W(32), .BYPASS(1'b1)) dut (
        .CLK(CLK), .nRST(nRST),
        .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rd(f_rd),
        .f_wen(f_wen), .f_w_data(f_w_data),
        .f_NV(f_NV), .f_DZ(f_DZ), .f_OF(f_OF), .f_UF(f_UF), .f_NX(f_NX),
        .csr_fflags_wen(csr_fflags_wen), .csr_fflags_in(csr_fflags_in),
        .csr_frm_wen(csr_frm_wen), .f_frm_in(f_frm_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .f_rs1_data(f_rs1_data), .f_rs2_data(f_rs2_data),
        .f_frm_out(f_frm_out), .f_flags(f_flags),
        .f_rs1_busy(f_rs1_busy), .f_rs2_busy(f_rs2_busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        f_wen = 0; f_NV = 0; f_DZ = 0; f_OF = 0; f_UF = 0; f_NX = 0;
        csr_fflags_wen = 0; csr_fflags_in = 0; csr_frm_wen = 0; f_frm_in = 0;
        issue_valid = 0; issue_rd = 0; f_rd = 0; f_w_data = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) begin
            f_rs1 = 5'(i); f_rs2 = 5'(31 - i);
            #1;
            n_checks++;
            if (f_rs1_data !== 32'h0 || f_rs2_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_data f%0d: got %h/%h expected 0", i, f_rs1_data, f_rs2_data);
            end
            n_checks++;
            if (f_rs1_busy !== 1'b0 || f_rs2_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy f%0d: got %b/%b expected 0", i, f_rs1_busy, f_rs2_busy);
            end
        end
        n_checks++;
        if (f_flags !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000", f_flags);
        end
        n_checks++;
        if (f_frm_out !== 3'b0) begin
            n_fail++; $display("FAIL reset_frm: got %0d expected 0", f_frm_out);
        end
    endtask

    task automatic test_write_read();
        f_wen = 1; f_rd = 5; f_w_data = 32'h3F800000; f_rs1 = 5; f_rs2 = 6;
        #1;
        n_checks++;
        if (f_rs1_data !== 32'h3F800000) begin
            n_fail++; $display("FAIL bypass_read: got %h expected 3f800000", f_rs1_data);
        end
        n_checks++;
        if (f_rs2_data !== 32'h0) begin
            n_fail++; $display("FAIL bypass_other_port: got %h expected 0", f_rs2_data);
        end
        tick();
        f_wen = 0; f_rs1 = 0; f_rs2 = 5;
        #1;
        n_checks++;
        if (f_rs2_data !== 32'h3F800000) begin
            n_fail++; $display("FAIL array_read_f5: got %h expected 3f800000", f_rs2_data);
        end
        n_checks++;
        if (f_rs1_data !== 32'h0) begin
            n_fail++; $display("FAIL f0_untouched: got %h expected 0", f_rs1_data);
        end
        f_wen = 1; f_rd = 0; f_w_data = 32'hDEADBEEF;
        tick();
        f_wen = 0;
        #1;
        n_checks++;
        if (f_rs1_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL f0_writable: got %h expected deadbeef", f_rs1_data);
        end
        n_checks++;
        if (f_rs2_data !== 32'h3F800000) begin
            n_fail++; $display("FAIL f5_kept: got %h expected 3f800000", f_rs2_data);
        end
    endtask

    task automatic test_flags();
        f_wen = 1; f_rd = 1; f_w_data = 32'h1; f_NX = 1;
        tick();
        f_NX = 0; f_OF = 1;
        tick();
        idle();
        #1;
        n_checks++;
        if (f_flags !== 5'b00101) begin
            n_fail++; $display("FAIL sticky_flags: got %b expected 00101", f_flags);
        end
        f_DZ = 1;
        tick();
        f_DZ = 0;
        n_checks++;
        if (f_flags !== 5'b00101) begin
            n_fail++; $display("FAIL flags_without_wen: got %b expected 00101", f_flags);
        end
        csr_fflags_wen = 1; csr_fflags_in = 5'b0; f_wen = 1; f_rd = 1; f_NV = 1;
        tick();
        idle();
        n_checks++;
        if (f_flags !== 5'b0) begin
            n_fail++; $display("FAIL csr_over_wen: got %b expected 00000", f_flags);
        end
        f_wen = 1; f_rd = 1; f_NV = 1; f_UF = 1;
        tick();
        idle();
        n_checks++;
        if (f_flags !== 5'b10010) begin
            n_fail++; $display("FAIL flags_accumulate: got %b expected 10010", f_flags);
        end
        csr_fflags_wen = 1; csr_fflags_in = 5'b01010;
        tick();
        idle();
        n_checks++;
        if (f_flags !== 5'b01010) begin
            n_fail++; $display("FAIL csr_fflags_write: got %b expected 01010", f_flags);
        end
    endtask

    task automatic test_frm();
        logic [2:0] vin [4] = '{3'b010, 3'b111, 3'b100, 3'b101};
        logic [2:0] vexp [4] = '{3'd2, 3'd2, 3'd4, 3'd4};
        for (int i = 0; i < 4; i++) begin
            csr_frm_wen = 1; f_frm_in = vin[i];
            tick();
            csr_frm_wen = 0;
            n_checks++;
            if (f_frm_out !== vexp[i]) begin
                n_fail++; $display("FAIL frm_write_%0d: got %0d expected %0d", vin[i], f_frm_out, vexp[i]);
            end
        end
        f_frm_in = 3'b001;
        tick();
        n_checks++;
        if (f_frm_out !== 3'd4) begin
            n_fail++; $display("FAIL frm_no_wen: got %0d expected 4", f_frm_out);
        end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0; f_rs1 = 7; f_rs2 = 7;
        #1;
        n_checks++;
        if (f_rs1_busy !== 1'b1 || f_rs2_busy !== 1'b1) begin
            n_fail++; $display("FAIL issue_busy: got %b/%b expected 1", f_rs1_busy, f_rs2_busy);
        end
        f_wen = 1; f_rd = 7; f_w_data = 32'h40490FDB;
        #1;
        n_checks++;
        if (f_rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL wb_same_cycle_busy: got %b expected 0", f_rs1_busy);
        end
        tick();
        f_wen = 0;
        #1;
        n_checks++;
        if (f_rs1_busy !== 1'b0 || f_rs1_data !== 32'h40490FDB) begin
            n_fail++; $display("FAIL wb_after: got busy=%b data=%h expected 0/40490fdb", f_rs1_busy, f_rs1_data);
        end
        issue_valid = 1; issue_rd = 7; f_wen = 1; f_rd = 7; f_w_data = 32'h11;
        tick();
        idle();
        #1;
        n_checks++;
        if (f_rs1_busy !== 1'b1) begin
            n_fail++; $display("FAIL issue_wins: got %b expected 1", f_rs1_busy);
        end
        f_rs2 = 9; f_wen = 1; f_rd = 9; f_w_data = 32'h22;
        tick();
        idle();
        #1;
        n_checks++;
        if (f_rs2_busy !== 1'b0 || f_rs2_data !== 32'h22 || f_rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wb_nonbusy: got busy9=%b data9=%h busy7=%b expected 0/00000022/1", f_rs2_busy, f_rs2_data, f_rs1_busy);
        end
        f_wen = 1; f_rd = 7; f_w_data = 32'h33;
        tick();
        idle();
        #1;
        n_checks++;
        if (f_rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL wb_resolves: got %b expected 0", f_rs1_busy);
        end
    endtask

    task automatic test_async_reset();
        issue_valid = 1; issue_rd = 3; f_wen = 1; f_rd = 3; f_w_data = 32'h12345678;
        tick();
        idle();
        csr_fflags_wen = 1; csr_fflags_in = 5'b11111;
        tick();
        idle();
        f_rs1 = 3; f_rs2 = 5;
        #1;
        n_checks++;
        if (f_rs1_busy !== 1'b1 || f_flags !== 5'b11111 || f_rs1_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL pre_reset: got busy=%b flags=%b data=%h expected 1/11111/12345678", f_rs1_busy, f_flags, f_rs1_data);
        end
        #1 nRST = 0;
        #1;
        n_checks++;
        if (f_rs1_busy !== 1'b0 || f_flags !== 5'b0 || f_frm_out !== 3'b0) begin
            n_fail++;
            $display("FAIL async_reset_state: got busy=%b flags=%b frm=%0d expected 0/00000/0", f_rs1_busy, f_flags, f_frm_out);
        end
        n_checks++;
        if (f_rs1_data !== 32'h0 || f_rs2_data !== 32'h0) begin
            n_fail++; $display("FAIL async_reset_data: got %h/%h expected 0", f_rs1_data, f_rs2_data);
        end
        tick();
        nRST = 1;
        tick();
        n_checks++;
        if (f_rs1_busy !== 1'b0 || f_rs1_data !== 32'h0) begin
            n_fail++; $display("FAIL post_reset: got busy=%b data=%h expected 0/0", f_rs1_busy, f_rs1_data);
        end
    endtask

    initial begin
        nRST = 0; f_rs1 = 0; f_rs2 = 0;
        idle();
        repeat (3) tick();
        nRST = 1;
        tick();
        test_reset();
        test_write_read();
        test_flags();
        test_frm();
        test_scoreboard();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
